// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state encoding and default widths.
package fetch_sequencer_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CLR0    = 4'd1,
    CLR1    = 4'd2,
    LD_PC   = 4'd3,
    LD_INST = 4'd4,
    LD_NPC  = 4'd5,
    ISSUE   = 4'd6,
    FLUSH   = 4'd7,
    HALTED  = 4'd8
  } fetchState_t;

  function automatic logic isBusy(fetchState_t s);
    return (s != IDLE) && (s != HALTED);
  endfunction

endpackage

// File: rtl/fetch_branch_latch.sv
// Holds a pending branch request and its target until the next PC load consumes it.
module fetch_branch_latch #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic [ADDR_W-1:0] target,
  input  logic              consume,
  input  logic              clear,
  output logic              pending,
  output logic [ADDR_W-1:0] branchPC
);

  // A halt discards the request outright; a fresh request outranks consumption so it is not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      branchPC <= '0;
    end else if (clear) begin
      pending  <= 1'b0;
    end else if (set) begin
      pending  <= 1'b1;
      branchPC <= target;
    end else if (consume) begin
      pending  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: clear sequence, then LD_PC -> LD_INST -> LD_NPC -> ISSUE with branch squash.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_req,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  input  logic              dec_ready,
  output logic              ldPC,
  output logic              ldNPC,
  output logic              ldInst,
  output logic              clrPC,
  output logic              clrNPC,
  output logic              clrInst,
  output logic              isBranchTaken,
  output logic [ADDR_W-1:0] branchPC,
  output logic              inst_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_count
);

  fetchState_t state;
  logic        pending;
  logic        ldFire;
  logic        haltAccept;

  // A pending branch must be taken even while stalled, otherwise redirection could deadlock.
  assign ldFire     = (state == LD_PC) && (!stall || pending);
  assign haltAccept = (state == ISSUE) && dec_ready && halt;
  assign busy       = isBusy(state);

  fetch_branch_latch #(.ADDR_W(ADDR_W)) branchLatch (
    .clk      (clk),
    .reset    (reset),
    .set      (branch_req && busy),
    .target   (branch_target),
    .consume  (ldFire),
    .clear    (haltAccept),
    .pending  (pending),
    .branchPC (branchPC)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE:    if (start) state <= CLR0;
        CLR0:    state <= CLR1;
        CLR1:    state <= LD_PC;
        LD_PC:   if (ldFire) state <= LD_INST;
        LD_INST: state <= branch_req ? FLUSH : LD_NPC;
        LD_NPC:  state <= branch_req ? FLUSH : ISSUE;
        ISSUE: begin
          // An accepted instruction is committed, so a same-cycle branch is applied at LD_PC instead of squashing it.
          if (dec_ready) begin
            fetch_count <= fetch_count + CNT_W'(1);
            state       <= halt ? HALTED : LD_PC;
          end else if (branch_req) begin
            state <= FLUSH;
          end
        end
        FLUSH:   state <= LD_PC;
        HALTED:  if (start) state <= CLR0;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ldPC          = 1'b0;
    ldNPC         = 1'b0;
    ldInst        = 1'b0;
    clrPC         = 1'b0;
    clrNPC        = 1'b0;
    clrInst       = 1'b0;
    isBranchTaken = 1'b0;
    inst_valid    = 1'b0;
    case (state)
      CLR0: begin
        clrPC   = 1'b1;
        clrInst = 1'b1;
      end
      CLR1:    clrNPC = 1'b1;
      LD_PC: begin
        ldPC          = ldFire;
        isBranchTaken = ldFire && pending;
      end
      LD_INST: ldInst = 1'b1;
      LD_NPC:  ldNPC = 1'b1;
      ISSUE:   inst_valid = 1'b1;
      FLUSH:   clrInst = 1'b1;
      default: ;
    endcase
  end

endmodule
